// File: rtl/ram_responder.sv
// ram_responder: word-addressed RAM behind the CPU memory request interface,
// with a configurable BUSY latency before each one-cycle ACCESS.
`default_nettype none

module ram_responder #(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] memaddr,
    input  logic [31:0] memstore,
    input  logic        memREN,
    input  logic        memWEN,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'((LAT > 0) ? LAT - 1 : 0);
    localparam bit ZERO_LAT = (LAT == 0);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            cap_wr, cap_wr_nxt;
    logic [AW-1:0]   cap_idx, cap_idx_nxt;
    logic [31:0]     cap_data, cap_data_nxt;

    // Not reset: contents survive nRST and start out all-zero.
    logic [31:0]     mem [DEPTH] = '{default: 32'd0};

    logic            req_any, req_valid, req_bad, in_range, same_req;
    logic [AW-1:0]   live_idx;
    logic            commit;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^memaddr[1:0];
    assign live_idx  = memaddr[AW+1:2];
    assign in_range  = ((memaddr >> (AW + 2)) == 32'd0);
    assign req_any   = memREN | memWEN;
    assign req_valid = (memREN ^ memWEN) & in_range;
    assign req_bad   = req_any & ~req_valid;
    assign same_req  = (memWEN == cap_wr) && (live_idx == cap_idx) && (memstore == cap_data);
    assign commit    = (state_nxt == ACCESS);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cap_wr_nxt   = cap_wr;
        cap_idx_nxt  = cap_idx;
        cap_data_nxt = cap_data;
        case (state)
            BUSY: begin
                if (!req_any) begin
                    state_nxt = FREE;
                end else if (req_bad) begin
                    state_nxt = ERROR;
                end else if (!same_req) begin
                    // Requester changed its mind: recapture and restart the latency.
                    cap_wr_nxt   = memWEN;
                    cap_idx_nxt  = live_idx;
                    cap_data_nxt = memstore;
                    cnt_nxt      = RELOAD;
                    state_nxt    = BUSY;
                end else if (cnt == '0) begin
                    state_nxt = ACCESS;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                // FREE, ACCESS and ERROR all treat the live request the same way.
                if (req_valid) begin
                    cap_wr_nxt   = memWEN;
                    cap_idx_nxt  = live_idx;
                    cap_data_nxt = memstore;
                    if (ZERO_LAT) begin
                        state_nxt = ACCESS;
                    end else begin
                        cnt_nxt   = RELOAD;
                        state_nxt = BUSY;
                    end
                end else if (req_bad) begin
                    state_nxt = ERROR;
                end else begin
                    state_nxt = FREE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= FREE;
            cnt      <= '0;
            cap_wr   <= 1'b0;
            cap_idx  <= '0;
            cap_data <= '0;
            ramload  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cap_wr   <= cap_wr_nxt;
            cap_idx  <= cap_idx_nxt;
            cap_data <= cap_data_nxt;
            if (commit && !cap_wr_nxt) begin
                ramload <= mem[cap_idx_nxt];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST && commit && cap_wr_nxt) begin
            mem[cap_idx_nxt] <= cap_data_nxt;
        end
    end

    assign ramstate = state;

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: one LAT=2 instance and one LAT=0 instance.
`default_nettype none

module tb_ram_responder;

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_ERROR  = 2'd3;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] a_addr = '0, a_store = '0, a_load;
    logic        a_ren = 1'b0, a_wen = 1'b0;
    logic [1:0]  a_state;
    logic [31:0] b_addr = '0, b_store = '0, b_load;
    logic        b_ren = 1'b0, b_wen = 1'b0;
    logic [1:0]  b_state;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          sel;
        logic [1:0]  st;
        logic [31:0] ld;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    ram_responder #(.LAT(2), .DEPTH(1024), .AW(10)) dut_a (
        .CLK(clk), .nRST(nrst),
        .memaddr(a_addr), .memstore(a_store),
        .memREN(a_ren), .memWEN(a_wen),
        .ramload(a_load), .ramstate(a_state)
    );

    ram_responder #(.LAT(0), .DEPTH(1024), .AW(10)) dut_b (
        .CLK(clk), .nRST(nrst),
        .memaddr(b_addr), .memstore(b_store),
        .memREN(b_ren), .memWEN(b_wen),
        .ramload(b_load), .ramstate(b_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the outputs
    // expected after the following rising edge.
    task automatic drv(input bit sel, input logic rn, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] st, input logic [31:0] ld, input string tag);
        exp_t e;
        @(negedge clk);
        nrst = rn;
        a_ren = 1'b0; a_wen = 1'b0; a_addr = '0; a_store = '0;
        b_ren = 1'b0; b_wen = 1'b0; b_addr = '0; b_store = '0;
        if (sel == 1'b0) begin
            a_ren = ren; a_wen = wen; a_addr = addr; a_store = data;
        end else begin
            b_ren = ren; b_wen = wen; b_addr = addr; b_store = data;
        end
        e.sel = sel; e.st = st; e.ld = ld; e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                if (mon_e.sel == 1'b0) begin
                    check({mon_e.tag, ".st"}, {30'd0, a_state}, {30'd0, mon_e.st});
                    check({mon_e.tag, ".ld"}, a_load, mon_e.ld);
                end else begin
                    check({mon_e.tag, ".st"}, {30'd0, b_state}, {30'd0, mon_e.st});
                    check({mon_e.tag, ".ld"}, b_load, mon_e.ld);
                end
            end
        end
    end

    initial begin
        // Reset both instances
        drv(0, 0, 0, 0, 32'h0, 32'h0, S_FREE, 32'h0, "rst_a");
        drv(1, 0, 0, 0, 32'h0, 32'h0, S_FREE, 32'h0, "rst_b");

        // Write 0x40 then read it back
        drv(0, 1, 0, 1, 32'h40, 32'hDEADBEEF, S_BUSY,   32'h0, "wr40_b1");
        drv(0, 1, 0, 1, 32'h40, 32'hDEADBEEF, S_BUSY,   32'h0, "wr40_b2");
        drv(0, 1, 0, 1, 32'h40, 32'hDEADBEEF, S_ACCESS, 32'h0, "wr40_acc");
        drv(0, 1, 0, 0, 32'h0,  32'h0,        S_FREE,   32'h0, "wr40_free");
        drv(0, 1, 1, 0, 32'h40, 32'h0, S_BUSY,   32'h0,        "rd40_b1");
        drv(0, 1, 1, 0, 32'h40, 32'h0, S_BUSY,   32'h0,        "rd40_b2");
        drv(0, 1, 1, 0, 32'h40, 32'h0, S_ACCESS, 32'hDEADBEEF, "rd40_acc");
        drv(0, 1, 0, 0, 32'h0,  32'h0, S_FREE,   32'hDEADBEEF, "rd40_free");

        // Address switch mid-BUSY restarts the latency
        drv(0, 1, 1, 0, 32'h40, 32'h0, S_BUSY,   32'hDEADBEEF, "sw_b1");
        drv(0, 1, 1, 0, 32'h44, 32'h0, S_BUSY,   32'hDEADBEEF, "sw_restart");
        drv(0, 1, 1, 0, 32'h44, 32'h0, S_BUSY,   32'hDEADBEEF, "sw_b2");
        drv(0, 1, 1, 0, 32'h44, 32'h0, S_ACCESS, 32'h0,        "sw_acc44");
        drv(0, 1, 0, 0, 32'h0,  32'h0, S_FREE,   32'h0,        "sw_free");

        // Back-to-back write then read of 0x8
        drv(0, 1, 0, 1, 32'h8, 32'h12345678, S_BUSY,   32'h0, "b2b_wb1");
        drv(0, 1, 0, 1, 32'h8, 32'h12345678, S_BUSY,   32'h0, "b2b_wb2");
        drv(0, 1, 0, 1, 32'h8, 32'h12345678, S_ACCESS, 32'h0, "b2b_wacc");
        drv(0, 1, 1, 0, 32'h8, 32'h0, S_BUSY,   32'h0,        "b2b_rb1");
        drv(0, 1, 1, 0, 32'h8, 32'h0, S_BUSY,   32'h0,        "b2b_rb2");
        drv(0, 1, 1, 0, 32'h8, 32'h0, S_ACCESS, 32'h12345678, "b2b_racc");
        drv(0, 1, 0, 0, 32'h0, 32'h0, S_FREE,   32'h12345678, "b2b_free");

        // Error handling
        drv(0, 1, 1, 1, 32'h0, 32'h0, S_ERROR, 32'h12345678, "err_both1");
        drv(0, 1, 1, 1, 32'h0, 32'h0, S_ERROR, 32'h12345678, "err_both2");
        drv(0, 1, 1, 1, 32'h0, 32'h0, S_ERROR, 32'h12345678, "err_both3");
        drv(0, 1, 0, 0, 32'h0, 32'h0, S_FREE,  32'h12345678, "err_clear");
        drv(0, 1, 1, 0, 32'h0001_0000, 32'h0, S_ERROR, 32'h12345678, "err_range");
        drv(0, 1, 0, 0, 32'h0, 32'h0, S_FREE,  32'h12345678, "err_range_clr");

        // Withdrawn write leaves memory untouched
        drv(0, 1, 0, 1, 32'h10, 32'hCAFEF00D, S_BUSY, 32'h12345678, "wd_b1");
        drv(0, 1, 0, 0, 32'h0,  32'h0,        S_FREE, 32'h12345678, "wd_free");
        drv(0, 1, 1, 0, 32'h10, 32'h0, S_BUSY,   32'h12345678, "wd_rb1");
        drv(0, 1, 1, 0, 32'h10, 32'h0, S_BUSY,   32'h12345678, "wd_rb2");
        drv(0, 1, 1, 0, 32'h10, 32'h0, S_ACCESS, 32'h0,        "wd_racc");
        drv(0, 1, 0, 0, 32'h0,  32'h0, S_FREE,   32'h0,        "wd_rfree");

        // Reset during a write's BUSY aborts it and clears ramload
        drv(0, 1, 1, 0, 32'h40, 32'h0, S_BUSY,   32'h0,        "pre_rb1");
        drv(0, 1, 1, 0, 32'h40, 32'h0, S_BUSY,   32'h0,        "pre_rb2");
        drv(0, 1, 1, 0, 32'h40, 32'h0, S_ACCESS, 32'hDEADBEEF, "pre_racc");
        drv(0, 1, 0, 0, 32'h0,  32'h0, S_FREE,   32'hDEADBEEF, "pre_free");
        drv(0, 1, 0, 1, 32'h20, 32'h55AA55AA, S_BUSY, 32'hDEADBEEF, "rstw_b1");
        drv(0, 0, 0, 1, 32'h20, 32'h55AA55AA, S_FREE, 32'h0,        "rstw_rst");
        drv(0, 1, 0, 0, 32'h0,  32'h0,        S_FREE, 32'h0,        "rstw_idle");
        drv(0, 1, 1, 0, 32'h20, 32'h0, S_BUSY,   32'h0, "rstw_rb1");
        drv(0, 1, 1, 0, 32'h20, 32'h0, S_BUSY,   32'h0, "rstw_rb2");
        drv(0, 1, 1, 0, 32'h20, 32'h0, S_ACCESS, 32'h0, "rstw_racc");
        drv(0, 1, 0, 0, 32'h0,  32'h0, S_FREE,   32'h0, "rstw_free");

        // Zero-latency instance: streams of back-to-back accesses
        drv(1, 1, 0, 1, 32'h0, 32'hB00000A0, S_ACCESS, 32'h0, "z_w0");
        drv(1, 1, 0, 1, 32'h4, 32'hB00000A1, S_ACCESS, 32'h0, "z_w4");
        drv(1, 1, 0, 1, 32'h8, 32'hB00000A2, S_ACCESS, 32'h0, "z_w8");
        drv(1, 1, 0, 1, 32'hC, 32'hB00000A3, S_ACCESS, 32'h0, "z_wC");
        drv(1, 1, 0, 0, 32'h0, 32'h0, S_FREE,   32'h0,        "z_wfree");
        drv(1, 1, 1, 0, 32'h4, 32'h0, S_ACCESS, 32'hB00000A1, "z_r4");
        drv(1, 1, 0, 0, 32'h0, 32'h0, S_FREE,   32'hB00000A1, "z_rfree");
        drv(1, 1, 1, 0, 32'hC, 32'h0, S_ACCESS, 32'hB00000A3, "z_sC");
        drv(1, 1, 1, 0, 32'h0, 32'h0, S_ACCESS, 32'hB00000A0, "z_s0");
        drv(1, 1, 1, 0, 32'h8, 32'h0, S_ACCESS, 32'hB00000A2, "z_s8");
        drv(1, 1, 1, 0, 32'h4, 32'h0, S_ACCESS, 32'hB00000A1, "z_s4");
        drv(1, 1, 0, 0, 32'h0, 32'h0, S_FREE,   32'hB00000A1, "z_sfree");

        repeat (3) @(negedge clk);
        check("drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
